// File: rtl/conv3x3_rgb_if.sv
// Window/kernel/output bundle for the 3x3 RGB convolution stage.
// Flow is valid-only: win_valid qualifies pixel00..pixel22 for one cycle,
// out_valid qualifies out_pixel for one cycle; there is no ready, so the
// producer may present a window every cycle and the consumer must take every output.
interface conv3x3_rgb_if;
  logic        win_valid;
  logic [23:0] pixel00, pixel01, pixel02;
  logic [23:0] pixel10, pixel11, pixel12;
  logic [23:0] pixel20, pixel21, pixel22;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [7:0]  coef_data;
  logic        coef_commit;
  logic        out_valid;
  logic [23:0] out_pixel;

  modport master (
    output win_valid,
    output pixel00, pixel01, pixel02,
    output pixel10, pixel11, pixel12,
    output pixel20, pixel21, pixel22,
    output coef_we, coef_addr, coef_data, coef_commit,
    input  out_valid, out_pixel
  );

  modport slave (
    input  win_valid,
    input  pixel00, pixel01, pixel02,
    input  pixel10, pixel11, pixel12,
    input  pixel20, pixel21, pixel22,
    input  coef_we, coef_addr, coef_data, coef_commit,
    output out_valid, out_pixel
  );
endinterface

// File: rtl/conv3x3_rgb.sv
// Three-stage per-channel 3x3 convolution (multiply, sum, round/shift/clamp)
// with a double-buffered signed kernel committed atomically.
module conv3x3_rgb #(
  parameter int SHIFT = 4
) (
  input logic          clk,
  input logic          rst,
  conv3x3_rgb_if.slave bus
);

  // SHIFT=7 cannot encode +128 in 8 signed bits, so identity saturates to +127.
  localparam logic signed [7:0]  ID_CENTER = (SHIFT >= 7) ? 8'sd127 : 8'(1 << SHIFT);
  localparam logic signed [21:0] RND       = (SHIFT > 0) ? 22'(1 << (SHIFT - 1)) : 22'sd0;

  logic [23:0]        win [9];
  logic signed [7:0]  shadow [9];
  logic signed [7:0]  active [9];
  logic               v1, v2;
  logic signed [16:0] prod_q [3][9];
  logic signed [20:0] sum_d [3];
  logic signed [20:0] sum_q [3];
  logic [7:0]         pix_d [3];

  assign win[0] = bus.pixel00;
  assign win[1] = bus.pixel01;
  assign win[2] = bus.pixel02;
  assign win[3] = bus.pixel10;
  assign win[4] = bus.pixel11;
  assign win[5] = bus.pixel12;
  assign win[6] = bus.pixel20;
  assign win[7] = bus.pixel21;
  assign win[8] = bus.pixel22;

  function automatic logic signed [16:0] mul(input logic [7:0] p, input logic signed [7:0] k);
    logic signed [16:0] a;
    logic signed [16:0] b;
    a = {9'b0, p};
    b = {{9{k[7]}}, k};
    return a * b;
  endfunction

  function automatic logic signed [20:0] sext(input logic signed [16:0] p);
    return {{4{p[16]}}, p};
  endfunction

  // Commit reads shadow before a same-cycle write lands, so the write waits for the next commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < 9; t++) begin
        shadow[t] <= (t == 4) ? ID_CENTER : 8'sd0;
        active[t] <= (t == 4) ? ID_CENTER : 8'sd0;
      end
    end else begin
      if (bus.coef_commit) active <= shadow;
      if (bus.coef_we && (bus.coef_addr <= 4'd8)) shadow[bus.coef_addr] <= bus.coef_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      for (int c = 0; c < 3; c++)
        for (int t = 0; t < 9; t++)
          prod_q[c][t] <= '0;
    end else begin
      v1 <= bus.win_valid;
      if (bus.win_valid)
        for (int c = 0; c < 3; c++)
          for (int t = 0; t < 9; t++)
            prod_q[c][t] <= mul(win[t][c*8 +: 8], active[t]);
    end
  end

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      sum_d[c] = '0;
      for (int t = 0; t < 9; t++)
        sum_d[c] = sum_d[c] + sext(prod_q[c][t]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      for (int c = 0; c < 3; c++) sum_q[c] <= '0;
    end else begin
      v2 <= v1;
      if (v1)
        for (int c = 0; c < 3; c++) sum_q[c] <= sum_d[c];
    end
  end

  always_comb begin
    logic signed [21:0] biased;
    logic signed [21:0] shifted;
    biased  = '0;
    shifted = '0;
    for (int c = 0; c < 3; c++) begin
      biased  = $signed({sum_q[c][20], sum_q[c]}) + RND;
      shifted = biased >>> SHIFT;
      if (shifted[21])              pix_d[c] = 8'd0;
      else if (shifted > 22'sd255)  pix_d[c] = 8'd255;
      else                          pix_d[c] = shifted[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_pixel <= '0;
    end else begin
      bus.out_valid <= v2;
      if (v2) bus.out_pixel <= {pix_d[2], pix_d[1], pix_d[0]};
    end
  end

endmodule

// File: tb/tb_conv3x3_rgb.sv
// Directed bench for conv3x3_rgb: identity, box, saturation, commit timing,
// async reset mid-stream and a back-to-back random burst against a model.
module tb_conv3x3_rgb;
  localparam int SHIFT = 4;

  logic clk = 1'b0;
  logic rst;
  conv3x3_rgb_if bus();

  conv3x3_rgb #(.SHIFT(SHIFT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_exp;
  int          run_len  = 0;
  int          max_run  = 0;
  int          ov_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_taps(input logic [23:0] w [9]);
    bus.pixel00 = w[0]; bus.pixel01 = w[1]; bus.pixel02 = w[2];
    bus.pixel10 = w[3]; bus.pixel11 = w[4]; bus.pixel12 = w[5];
    bus.pixel20 = w[6]; bus.pixel21 = w[7]; bus.pixel22 = w[8];
  endtask

  task automatic set_uniform(input logic [23:0] v);
    logic [23:0] w [9];
    for (int t = 0; t < 9; t++) w[t] = v;
    set_taps(w);
  endtask

  task automatic write_coef(input int addr, input logic [7:0] data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'(addr);
    bus.coef_data = data;
    tick();
    bus.coef_we   = 1'b0;
  endtask

  task automatic commit_pulse();
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_commit = 1'b0;
  endtask

  task automatic send_uniform(input logic [23:0] v, input logic [23:0] expv);
    set_uniform(v);
    bus.win_valid = 1'b1;
    exp_q.push_back(expv);
    tick();
    bus.win_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 8; i++)
      if (exp_q.size() != 0) tick();
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [23:0] model(input logic [23:0] w [9], input logic [7:0] k [9]);
    logic [23:0] r;
    int s;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      s = 0;
      for (int t = 0; t < 9; t++)
        s += int'(w[t][c*8 +: 8]) * int'($signed(k[t]));
      s = (s + (1 << (SHIFT - 1))) >>> SHIFT;
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      r[c*8 +: 8] = 8'(s);
    end
    return r;
  endfunction

  // Scoreboard: every output must match the oldest expected window, in order.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.out_valid === 1'b1) begin
        ov_total++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("stream_pixel", 32'(bus.out_pixel), 32'(mon_exp));
        end
      end else begin
        run_len = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] w [9];
    logic [7:0]  kern [9];
    int          seen;

    rst = 1'b1;
    bus.win_valid = 1'b0;
    set_uniform(24'h0);
    bus.coef_we = 1'b0;
    bus.coef_addr = 4'd0;
    bus.coef_data = 8'd0;
    bus.coef_commit = 1'b0;
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pixel", 32'(bus.out_pixel), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Identity kernel after reset with exact 3-cycle latency and hold.
    for (int t = 0; t < 9; t++) w[t] = 24'($urandom);
    w[4] = 24'h123456;
    set_taps(w);
    bus.win_valid = 1'b1;
    exp_q.push_back(24'h123456);
    tick();
    bus.win_valid = 1'b0;
    tick();
    check("id_not_yet_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("id_valid", 32'(bus.out_valid), 32'd1);
    check("id_pixel", 32'(bus.out_pixel), 32'h123456);
    tick();
    check("id_valid_drop", 32'(bus.out_valid), 32'd0);
    check("id_pixel_hold", 32'(bus.out_pixel), 32'h123456);

    // Box kernel: (9*255 + 8) >> 4 = 143.
    for (int a = 0; a < 9; a++) write_coef(a, 8'h01);
    commit_pulse();
    send_uniform(24'hFFFFFF, 24'h8F8F8F);
    drain("box_drain");

    // Saturation high and low.
    for (int a = 0; a < 9; a++) write_coef(a, (a == 4) ? 8'h7F : 8'h00);
    commit_pulse();
    send_uniform(24'hFF00FF, 24'hFF00FF);
    for (int a = 0; a < 9; a++) write_coef(a, (a == 4) ? 8'h00 : 8'hFF);
    commit_pulse();
    send_uniform(24'hFFFFFF, 24'h000000);
    drain("sat_drain");

    // Commit mid-stream; address 12 is out of range and must not alias tap 4.
    for (int a = 0; a < 9; a++) write_coef(a, (a == 4) ? 8'h10 : 8'h00);
    commit_pulse();
    for (int j = 0; j < 16; j++) begin
      set_uniform(24'h101010);
      bus.win_valid   = 1'b1;
      exp_q.push_back((j <= 10) ? 24'h101010 : 24'h090909);
      bus.coef_we     = (j <= 9);
      bus.coef_addr   = (j == 9) ? 4'd12 : 4'(j);
      bus.coef_data   = (j == 9) ? 8'h80 : 8'h01;
      bus.coef_commit = (j == 10);
      tick();
    end
    bus.win_valid = 1'b0;
    bus.coef_we = 1'b0;
    bus.coef_commit = 1'b0;
    drain("commit_stream_drain");

    // Same-cycle write+commit: the write becomes active only at the next commit.
    bus.coef_we = 1'b1;
    bus.coef_addr = 4'd4;
    bus.coef_data = 8'h09;
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_we = 1'b0;
    bus.coef_commit = 1'b0;
    send_uniform(24'h101010, 24'h090909);
    commit_pulse();
    send_uniform(24'h101010, 24'h111111);
    drain("same_cycle_drain");

    // Async reset after the 2nd of 5 windows; none of them may come out.
    for (int j = 0; j < 2; j++) begin
      set_uniform(24'h202020 + 24'(j));
      bus.win_valid = 1'b1;
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_pixel", 32'(bus.out_pixel), 32'd0);
    for (int j = 2; j < 5; j++) begin
      set_uniform(24'h202020 + 24'(j));
      tick();
    end
    rst = 1'b0;
    bus.win_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    check("no_stale_after_rst", 32'(seen), 32'd0);
    for (int t = 0; t < 9; t++) w[t] = 24'($urandom);
    w[4] = 24'hABCDEF;
    set_taps(w);
    bus.win_valid = 1'b1;
    exp_q.push_back(24'hABCDEF);
    tick();
    bus.win_valid = 1'b0;
    drain("rst_identity_drain");

    // Back-to-back random burst under a random kernel.
    for (int a = 0; a < 9; a++) begin
      kern[a] = 8'($urandom_range(0, 255));
      write_coef(a, kern[a]);
    end
    commit_pulse();
    max_run = 0;
    ov_total = 0;
    for (int j = 0; j < 16; j++) begin
      for (int t = 0; t < 9; t++) w[t] = 24'($urandom);
      set_taps(w);
      bus.win_valid = 1'b1;
      exp_q.push_back(model(w, kern));
      tick();
    end
    bus.win_valid = 1'b0;
    drain("burst_drain");
    check("burst_out_count", 32'(ov_total), 32'd16);
    check("burst_contiguous", 32'(max_run), 32'd16);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/conv3x3_rgb.md
# conv3x3_rgb

Pipelined 3x3 convolution stage that sits directly downstream of the 4-line window buffer. It consumes the nine 24-bit window pixels each cycle the buffer presents a valid window. It applies a programmable signed 3x3 kernel independently to the three 8-bit channels of each pixel, with rounding, shifting and saturation. It emits one filtered 24-bit pixel per input window with a fixed latency of 3 cycles. Kernel coefficients are double-buffered so a new kernel can be staged mid-frame and committed atomically.

## Interface
- SHIFT, 4, right-shift applied to each channel sum (valid range 0..7)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- win_valid  in  1  window pixels valid this cycle (asserted one cycle after the buffer's enable)
- pixel00..pixel22  in  24 each  3x3 window, row-major (pixelRC); channels [23:16],[15:8],[7:0], unsigned
- coef_we  in  1  write strobe into shadow kernel bank
- coef_addr  in  4  coefficient index = row*3+col (0..8); 9..15 ignored
- coef_data  in  8  signed two's-complement coefficient
- coef_commit  in  1  single-cycle pulse; copy shadow bank to active bank
- out_valid  out  1  out_pixel valid
- out_pixel  out  24  filtered pixel, same channel packing as input

## Operation
- Each channel is processed identically and independently, with no cross-channel terms.
- Stage 1 (registered): nine products, pixel channel (8b unsigned, zero-extended) x active coefficient (8b signed) -> 17b signed each, 27 products total.
- Stage 2 (registered): per-channel sum of 9 products -> 21b signed; overflow impossible.
- Stage 3 (registered output):
  - add rounding constant 2^(SHIFT-1), or 0 when SHIFT=0;
  - arithmetic shift right by SHIFT;
  - clamp: result <0 -> 0, >255 -> 255, else low 8 bits.
- Valid pipeline: win_valid is delayed by 3 registers to give out_valid.
  - The data registers load only when the corresponding stage valid is 1; otherwise they hold.
  - There is no backpressure. A new window may be accepted every cycle.
- Kernel banks:
  - coef_we with coef_addr<=8 writes coef_data into shadow[coef_addr]; other addresses are a no-op.
  - coef_commit copies all 9 shadow entries into active in one cycle. A window sampled in the cycle after commit uses the new kernel. Windows already in the pipeline keep the products they computed.
  - coef_we and coef_commit in the same cycle: the commit copies the pre-write shadow contents; the write lands in shadow only.
  - Commit without any prior writes re-copies the current shadow and is harmless.
- Reset (async, any time, including mid-stream):
  - out_valid=0, out_pixel=0, all stage valids=0, all pipeline data=0;
  - both banks = identity kernel: entry 4 = 2^SHIFT, all others 0. For SHIFT=7 the center is +127 (saturated encoding), and identity is then approximate.
  - In-flight windows are discarded. There is no output for them after reset release.

## Timing
- Latency: win_valid sampled at edge N -> out_valid=1 and out_pixel after edge N+3.
- Throughput: 1 pixel/cycle; back-to-back windows give back-to-back outputs in order.
- out_valid is high for exactly as many cycles as win_valid was, shifted by 3.
- out_pixel holds its last value while out_valid=0.
- Coefficient write-to-effect: write at edge W, commit at edge C>=W+1 -> window at edge C+1 or later uses the new value.

## Test plan
- Identity after reset (SHIFT=4): release rst, drive pixel11=0x123456 with the other taps random, win_valid=1 for 1 cycle -> out_valid pulses 3 cycles later with out_pixel=0x123456.
- Box kernel: write coef 0..8 = 0x01, commit; all taps = 0xFFFFFF -> each channel (2295+8)>>4=143 -> out_pixel=0x8F8F8F.
- Saturation: coef4=0x7F, others 0, commit, all taps 0xFF00FF -> 0xFF00FF. Then coef4=0x00, others 0xFF (-1), commit, all taps 0xFFFFFF -> 0x000000.
- Commit timing: stream continuous windows of 0x101010 under identity; write box kernel, pulse commit mid-stream -> outputs 0x101010 up to the window sampled at the commit edge, then 0x090909 ((144+8)>>4=9) from the next window on. Also apply coef_we and coef_commit in the same cycle and confirm the written value is not active until the following commit.
- Reset mid-operation: 5 consecutive windows, assert rst after the 2nd -> out_valid and out_pixel go 0 immediately (asynchronously), no stale outputs after release, kernel back to identity.
- Throughput: 16 back-to-back random windows against a reference model -> 16 consecutive out_valid cycles, all match, in order.
